// File: rtl/dk_sfx_pkg.sv
// Shared types and helpers for the discrete sound-effect sequencer.
// Channel state encoding, counter width and load-value clamping live here.
package dk_sfx_pkg;

  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } sfx_state_t;

  // Keeps sample counts in 1..CNT_MAX so a zero or oversized parameter still gives a sane load.
  function automatic logic [CNT_W-1:0] clamp_samples(input int n);
    if (n < 1)
      return CNT_W'(1);
    else if (n > CNT_MAX)
      return CNT_W'(CNT_MAX);
    else
      return CNT_W'(n);
  endfunction

endpackage

// File: rtl/dk_sfx_channel.sv
// One effect channel: IDLE/ACTIVE/HOLD/RELEASE FSM with a saturating 16-bit down-counter.
// Everything advances only on the audio sample strobe.
module dk_sfx_channel
  import dk_sfx_pkg::*;
#(
  parameter int HOLD_SAMPLES    = 2400,
  parameter int RELEASE_SAMPLES = 96
) (
  input  logic       clk,
  input  logic       I_RSTn,
  input  logic       audio_clk_en,
  input  logic       req,
  input  logic       grant,
  input  logic       preempt_kill,
  output logic [1:0] state,
  output logic       en
);

  localparam logic [CNT_W-1:0] HOLD_LD = clamp_samples(HOLD_SAMPLES);
  localparam logic [CNT_W-1:0] REL_LD  = clamp_samples(RELEASE_SAMPLES);

  sfx_state_t       st;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_dec;

  assign cnt_dec = (cnt == '0) ? '0 : cnt - 1'b1;
  assign state   = st;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      st  <= ST_IDLE;
      cnt <= '0;
      en  <= 1'b0;
    end else if (audio_clk_en) begin
      case (st)
        ST_IDLE: begin
          if (grant) begin
            st  <= ST_ACTIVE;
            cnt <= HOLD_LD;
            en  <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (preempt_kill || (!req && cnt == '0)) begin
            st  <= ST_RELEASE;
            cnt <= REL_LD;
            en  <= 1'b0;
          end else begin
            cnt <= cnt_dec;
            if (!req) st <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // A preempted hold is abandoned outright; re-arming keeps the running count.
          if (preempt_kill || (!req && cnt <= CNT_W'(1))) begin
            st  <= ST_RELEASE;
            cnt <= REL_LD;
            en  <= 1'b0;
          end else begin
            cnt <= cnt_dec;
            if (req) st <= ST_ACTIVE;
          end
        end
        ST_RELEASE: begin
          if (cnt <= CNT_W'(1)) begin
            st  <= ST_IDLE;
            cnt <= '0;
          end else begin
            cnt <= cnt_dec;
          end
        end
        default: begin
          st  <= ST_IDLE;
          cnt <= '0;
          en  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dk_sfx_sequencer.sv
// CPU sound-port latch plus fixed-priority slot arbiter feeding NUM_CH effect channels.
// At most one grant per sample; a lower-index request may evict the highest-index occupant.
module dk_sfx_sequencer
  import dk_sfx_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int MAX_ACTIVE      = 2,
  parameter int HOLD_SAMPLES    = 2400,
  parameter int RELEASE_SAMPLES = 96
) (
  input  logic                         clk,
  input  logic                         I_RSTn,
  input  logic                         audio_clk_en,
  input  logic                         cpu_wr,
  input  logic [NUM_CH-1:0]            cpu_data,
  output logic [NUM_CH-1:0]            sfx_en,
  output logic [$clog2(NUM_CH+1)-1:0]  active_count,
  output logic                         preempt
);

  localparam int CW = $clog2(NUM_CH+1);

  logic [NUM_CH-1:0]      req;
  logic [NUM_CH-1:0]      occ;
  logic [NUM_CH-1:0]      cand;
  logic [NUM_CH-1:0]      grant;
  logic [NUM_CH-1:0]      kill;
  logic [NUM_CH-1:0][1:0] ch_state;
  logic [CW-1:0]          occ_cnt;
  logic [CW-1:0]          en_cnt;
  logic                   preempt_nxt;
  int                     cand_idx;
  int                     occ_top;
  logic                   have_cand;

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn)     req <= '0;
    else if (cpu_wr) req <= cpu_data;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    occ         = '0;
    cand        = '0;
    grant       = '0;
    kill        = '0;
    occ_cnt     = '0;
    en_cnt      = '0;
    preempt_nxt = 1'b0;
    cand_idx    = 0;
    occ_top     = 0;
    have_cand   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      occ[i]  = (sfx_state_t'(ch_state[i]) == ST_ACTIVE) || (sfx_state_t'(ch_state[i]) == ST_HOLD);
      cand[i] = (sfx_state_t'(ch_state[i]) == ST_IDLE) && req[i];
      occ_cnt = occ_cnt + CW'(occ[i]);
      en_cnt  = en_cnt + CW'(sfx_en[i]);
      if (occ[i]) occ_top = i;
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        cand_idx  = i;
        have_cand = 1'b1;
      end
    end
    if (have_cand) begin
      if (int'(occ_cnt) < MAX_ACTIVE) begin
        grant[cand_idx] = 1'b1;
      end else if (occ_top > cand_idx) begin
        grant[cand_idx] = 1'b1;
        kill[occ_top]   = 1'b1;
        preempt_nxt     = 1'b1;
      end
    end
  end

  // Count comes straight from the channel enable flops, so it can never disagree with sfx_en.
  assign active_count = en_cnt;

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) preempt <= 1'b0;
    else         preempt <= audio_clk_en & preempt_nxt;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dk_sfx_channel #(
      .HOLD_SAMPLES   (HOLD_SAMPLES),
      .RELEASE_SAMPLES(RELEASE_SAMPLES)
    ) u_ch (
      .clk         (clk),
      .I_RSTn      (I_RSTn),
      .audio_clk_en(audio_clk_en),
      .req         (req[g]),
      .grant       (grant[g]),
      .preempt_kill(kill[g]),
      .state       (ch_state[g]),
      .en          (sfx_en[g])
    );
  end

endmodule

// File: tb/tb_dk_sfx_sequencer.sv
// Directed bench for dk_sfx_sequencer with HOLD=8, RELEASE=4, 4 channels, 2 slots.
// A second instance with MAX_ACTIVE=NUM_CH shares the stimulus and must never preempt.
module tb_dk_sfx_sequencer;

  logic       clk = 1'b0;
  logic       I_RSTn;
  logic       audio_clk_en;
  logic       cpu_wr;
  logic [3:0] cpu_data;
  logic [3:0] sfx_en;
  logic [2:0] active_count;
  logic       preempt;
  logic [3:0] full_en;
  logic [2:0] full_cnt;
  logic       full_pre;

  int n_checks = 0;
  int n_fail   = 0;
  int full_pre_seen = 0;

  always #5 clk = ~clk;

  dk_sfx_sequencer #(
    .NUM_CH(4), .MAX_ACTIVE(2), .HOLD_SAMPLES(8), .RELEASE_SAMPLES(4)
  ) u_dut (
    .clk(clk), .I_RSTn(I_RSTn), .audio_clk_en(audio_clk_en), .cpu_wr(cpu_wr),
    .cpu_data(cpu_data), .sfx_en(sfx_en), .active_count(active_count), .preempt(preempt)
  );

  dk_sfx_sequencer #(
    .NUM_CH(4), .MAX_ACTIVE(4), .HOLD_SAMPLES(8), .RELEASE_SAMPLES(4)
  ) u_dut_full (
    .clk(clk), .I_RSTn(I_RSTn), .audio_clk_en(audio_clk_en), .cpu_wr(cpu_wr),
    .cpu_data(cpu_data), .sfx_en(full_en), .active_count(full_cnt), .preempt(full_pre)
  );

  always @(posedge clk) if (full_pre === 1'b1) full_pre_seen++;

  typedef struct {
    logic       rst;
    logic       stb;
    logic       wr;
    logic [3:0] data;
    logic [3:0] exp_en;
    logic [2:0] exp_cnt;
    logic       exp_pre;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic stb, input logic wr, input logic [3:0] d);
    @(negedge clk);
    I_RSTn       = !rst;
    audio_clk_en = stb;
    cpu_wr       = wr;
    cpu_data     = d;
    @(posedge clk);
    #1;
    audio_clk_en = 1'b0;
    cpu_wr       = 1'b0;
  endtask

  function automatic void add(input logic rst, input logic stb, input logic wr, input logic [3:0] d,
                              input logic [3:0] en, input logic [2:0] cnt, input logic pre);
    vec_t v;
    v.rst = rst; v.stb = stb; v.wr = wr; v.data = d;
    v.exp_en = en; v.exp_cnt = cnt; v.exp_pre = pre;
    vecs.push_back(v);
  endfunction

  function automatic void add_strobes(input int n, input logic [3:0] en, input logic [2:0] cnt);
    for (int i = 0; i < n; i++) add(1'b0, 1'b1, 1'b0, 4'h0, en, cnt, 1'b0);
  endfunction

  initial begin
    logic [3:0] seen_en;
    I_RSTn = 1'b0; audio_clk_en = 1'b0; cpu_wr = 1'b0; cpu_data = 4'h0;

    // Short pulse: 8 strobes on, 4 in release, rewrite during release waits for IDLE.
    add(1, 0, 0, 4'h0, 4'h0, 0, 0);
    add(0, 0, 1, 4'h1, 4'h0, 0, 0);
    add(0, 1, 0, 4'h0, 4'h1, 1, 0);
    add(0, 0, 1, 4'h0, 4'h1, 1, 0);
    add_strobes(7, 4'h1, 1);
    add_strobes(2, 4'h0, 0);
    add(0, 0, 1, 4'h1, 4'h0, 0, 0);
    add_strobes(3, 4'h0, 0);
    add_strobes(1, 4'h1, 1);

    // Slot cap with one grant per sample, then channel 1 evicts channel 3.
    add(1, 0, 0, 4'h0, 4'h0, 0, 0);
    add(0, 0, 1, 4'hC, 4'h0, 0, 0);
    add_strobes(1, 4'h4, 1);
    add_strobes(1, 4'hC, 2);
    add(0, 0, 1, 4'hE, 4'hC, 2, 0);
    add(0, 1, 0, 4'h0, 4'h6, 2, 1);
    add(0, 0, 0, 4'h0, 4'h6, 2, 0);
    add_strobes(1, 4'h6, 2);

    // Higher index never evicts a lower one; channel 2 waits for channel 1 to finish hold.
    add(1, 0, 0, 4'h0, 4'h0, 0, 0);
    add(0, 0, 1, 4'h3, 4'h0, 0, 0);
    add_strobes(1, 4'h1, 1);
    add_strobes(1, 4'h3, 2);
    add(0, 0, 1, 4'h7, 4'h3, 2, 0);
    add_strobes(2, 4'h3, 2);
    add(0, 0, 1, 4'h5, 4'h3, 2, 0);
    add_strobes(5, 4'h3, 2);
    add_strobes(1, 4'h1, 1);
    add_strobes(1, 4'h5, 2);

    // Re-arm in HOLD: enable stays high and total on-time is still 8 strobes.
    add(1, 0, 0, 4'h0, 4'h0, 0, 0);
    add(0, 0, 1, 4'h1, 4'h0, 0, 0);
    add_strobes(4, 4'h1, 1);
    add(0, 0, 1, 4'h0, 4'h1, 1, 0);
    add_strobes(2, 4'h1, 1);
    add(0, 0, 1, 4'h1, 4'h1, 1, 0);
    add_strobes(1, 4'h1, 1);
    add(0, 0, 1, 4'h0, 4'h1, 1, 0);
    add_strobes(1, 4'h1, 1);
    add_strobes(1, 4'h0, 0);

    // Write coinciding with a strobe only takes effect on the next strobe.
    add(1, 0, 0, 4'h0, 4'h0, 0, 0);
    add(0, 1, 1, 4'h1, 4'h0, 0, 0);
    add(0, 0, 0, 4'h0, 4'h0, 0, 0);
    add_strobes(1, 4'h1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].stb, vecs[i].wr, vecs[i].data);
      check($sformatf("vec%0d sfx_en", i), 32'(sfx_en), 32'(vecs[i].exp_en));
      check($sformatf("vec%0d active_count", i), 32'(active_count), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d preempt", i), 32'(preempt), 32'(vecs[i].exp_pre));
    end

    // Reset mid-hold with req latched high: outputs clear in the same cycle and stay clear.
    step(1, 0, 0, 4'h0);
    step(0, 0, 1, 4'h1);
    step(0, 1, 0, 4'h0);
    step(0, 0, 1, 4'h0);
    step(0, 1, 0, 4'h0);
    step(0, 0, 1, 4'h1);
    check("hold before reset sfx_en", 32'(sfx_en), 32'h1);
    @(negedge clk);
    I_RSTn = 1'b0;
    #1;
    check("async reset sfx_en", 32'(sfx_en), 32'h0);
    check("async reset active_count", 32'(active_count), 32'h0);
    seen_en = 4'h0;
    for (int i = 0; i < 100; i++) begin
      step(0, 1, 0, 4'h0);
      seen_en |= sfx_en;
    end
    check("post reset idle sfx_en", 32'(seen_en), 32'h0);
    check("full slots preempt pulses", 32'(full_pre_seen), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
